// File: rtl/csel_sub_pipe.sv
// csel_sub_pipe: two-stage pipelined carry-select subtractor (diff = a - b).
// Stage 1 resolves the lower half and precomputes both upper-half candidates;
// stage 2 selects the upper half by the lower carry and forms the flags.
// Valid/ready stream on both sides, capacity of two in-flight operations.
module csel_sub_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);
   localparam int HALF = WIDTH / 2;

   // stage 1 registers
   logic            r_s1_vld;
   logic [HALF-1:0] r_lo_d;
   logic            r_c_lo;
   logic [HALF-1:0] r_hi0;
   logic            r_co0;
   logic [HALF-1:0] r_hi1;
   logic            r_co1;
   logic            r_a_msb;
   logic            r_b_msb;

   // stage 2 registers
   logic             r_s2_vld;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_ovf;
   logic             r_zero;

   // stage 1 combinational: subtraction as a + ~b + 1, split into halves
   logic [WIDTH-1:0] w_nb;
   logic [HALF:0]    w_lo;
   logic [HALF:0]    w_hi0;
   logic [HALF:0]    w_hi1;

   assign w_nb  = ~b;
   assign w_lo  = {1'b0, a[HALF-1:0]} + {1'b0, w_nb[HALF-1:0]} + (HALF+1)'(1);
   assign w_hi0 = {1'b0, a[WIDTH-1:HALF]} + {1'b0, w_nb[WIDTH-1:HALF]};
   // max of w_hi0 is 2^(HALF+1)-2, so the +1 never wraps the HALF+1 bit result
   assign w_hi1 = w_hi0 + (HALF+1)'(1);

   // handshake
   logic w_acc;
   logic w_s2_ld;
   logic w_pop;

   assign in_ready = !r_s1_vld || !r_s2_vld || out_ready;
   assign w_acc    = in_valid && in_ready;
   assign w_s2_ld  = r_s1_vld && (!r_s2_vld || out_ready);
   assign w_pop    = r_s2_vld && out_ready;

   // stage 2 combinational: carry select and flag formation
   logic [HALF-1:0]  w_hi;
   logic             w_co;
   logic [WIDTH-1:0] w_diff;
   logic             w_ovf;

   assign w_hi   = r_c_lo ? r_hi1 : r_hi0;
   assign w_co   = r_c_lo ? r_co1 : r_co0;
   assign w_diff = {w_hi, r_lo_d};
   assign w_ovf  = (r_a_msb != r_b_msb) && (w_diff[WIDTH-1] != r_a_msb);

   // stage 1: capture operands' half results on accept, drop valid when it drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_lo_d   <= '0;
         r_c_lo   <= 1'b0;
         r_hi0    <= '0;
         r_co0    <= 1'b0;
         r_hi1    <= '0;
         r_co1    <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
      end else if (w_acc) begin
         // in_ready guarantees stage 1 is empty or advancing this edge
         r_s1_vld <= 1'b1;
         r_lo_d   <= w_lo[HALF-1:0];
         r_c_lo   <= w_lo[HALF];
         r_hi0    <= w_hi0[HALF-1:0];
         r_co0    <= w_hi0[HALF];
         r_hi1    <= w_hi1[HALF-1:0];
         r_co1    <= w_hi1[HALF];
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
      end else if (w_s2_ld) begin
         r_s1_vld <= 1'b0;
      end
   end

   // stage 2: load selected result, hold while stalled, clear valid on consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_s2_ld) begin
         r_s2_vld <= 1'b1;
         r_diff   <= w_diff;
         r_borrow <= ~w_co;
         r_ovf    <= w_ovf;
         r_zero   <= (w_diff == '0);
      end else if (w_pop) begin
         r_s2_vld <= 1'b0;
      end
   end

   assign out_valid = r_s2_vld;
   assign diff      = r_diff;
   assign borrow    = r_borrow;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_csel_sub_pipe.sv
// Scoreboard bench for csel_sub_pipe: expected results are queued on accept,
// a negedge monitor pops and compares whenever a result is consumed.
module tb_csel_sub_pipe;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;
   logic         zero;

   csel_sub_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t q[$];
   bit   sb_en = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      e.diff   = x - y;
      e.borrow = (x < y);
      e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
      e.zero   = (e.diff == '0);
      return e;
   endfunction

   // monitor: pop on consume, check held outputs stay stable while stalled
   exp_t held;
   bit   held_v = 1'b0;
   always @(negedge clk) begin
      exp_t cur, e;
      if (rst) begin
         held_v = 1'b0;
      end else begin
         cur = '{diff: diff, borrow: borrow, ovf: ovf, zero: zero};
         if (held_v && out_valid) chk("stall_hold", 64'(cur), 64'(held));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               chk("result", 64'(cur), 64'(e));
            end
         end
         held_v = out_valid && !out_ready;
         held   = cur;
      end
   end

   // drive one pair until accepted; expectation queued on the accept edge
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
      bit ok = 1'b0;
      in_valid = 1'b1; a = x; b = y;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            if (sb_en) q.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // directed vectors: a, b, hand-computed diff/borrow/ovf/zero
   logic [W-1:0] va[8] = '{32'h0001_0000, 32'h5, 32'h1234_5678, 32'h8000_0000,
                           32'h7FFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
   logic [W-1:0] vb[8] = '{32'h0000_0001, 32'h7, 32'h1234_5678, 32'h1,
                           32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0};
   exp_t ve[8] = '{'{32'h0000_FFFF, 1'b0, 1'b0, 1'b0},
                   '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0},
                   '{32'h0000_0000, 1'b0, 1'b0, 1'b1},
                   '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
                   '{32'h8000_0000, 1'b1, 1'b1, 1'b0},
                   '{32'h0000_0000, 1'b0, 1'b0, 1'b1},
                   '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
                   '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};

   logic [W-1:0] ba[4] = '{32'd10, 32'd3, 32'd100, 32'h4000_0000};
   logic [W-1:0] bb[4] = '{32'd3, 32'd10, 32'd100, 32'hC000_0000};
   exp_t be[4] = '{'{32'h0000_0007, 1'b0, 1'b0, 1'b0},
                   '{32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0},
                   '{32'h0000_0000, 1'b0, 1'b0, 1'b1},
                   '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};

   bit bp_done = 1'b0;
   int nacc    = 0;
   int c0;

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_outputs",   64'({diff, borrow, ovf, zero}), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // latency: stage 1 only after the accept edge, result after the next
      send(va[0], vb[0], ve[0]);
      @(negedge clk);
      chk("lat_s1_only", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_out", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // back-to-back directed vectors: one accept per cycle
      c0 = cyc;
      for (int i = 1; i < 8; i++) send(va[i], vb[i], ve[i]);
      chk("throughput_cycles", 64'(cyc - c0), 64'd7);
      drain();

      // back-pressure: only two fit, outputs held, then drain in order
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(ba[i], bb[i], be[i]);
            bp_done = 1'b1;
         end
      join_none
      repeat (6) @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_accepted", 64'(q.size()), 64'd2);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !bp_done; i++) @(posedge clk);
      chk("bp_done", 64'(bp_done), 64'd1);
      #1;
      drain();

      // reset mid-flight: two pairs stalled, async reset between edges
      out_ready = 1'b0;
      sb_en = 1'b0;
      send(32'd9, 32'd4, model(32'd9, 32'd4));
      send(32'd8, 32'd2, model(32'd8, 32'd2));
      @(negedge clk);
      chk("mid_full", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
      chk("mid_rst_diff",      64'(diff),      64'd0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1; sb_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale", 64'(out_valid), 64'd0);
      end

      // random streaming with random valid/ready
      for (int c = 0; c < 60000 && nacc < 10000; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = $urandom;
         b         = ($urandom_range(0, 15) == 0) ? a : $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            q.push_back(model(a, b));
            nacc++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rand_accepted", 64'(nacc), 64'd10000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
